// File: rtl/mem_access_ctrl.sv
// Memory access controller: routes one CPU request to ROM or RAM with wait states.
// Optional macro SEL_CHECK_EN cross-checks the decoder select against the address.
module mem_access_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 32'h0010_0000,
  parameter int unsigned           ROM_WAIT   = 1,
  parameter int unsigned           RAM_WAIT   = 2,
  parameter int unsigned           MEM_AW     = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  sel_i,
  output logic                  ready_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
`ifdef SEL_CHECK_EN
  output logic                  sel_mismatch_o,
`endif
  output logic [MEM_AW-1:0]     rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  output logic [MEM_AW-1:0]     ram_addr_o,
  output logic                  ram_we_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // state  | meaning
  // IDLE   | waiting for req_i, samples request and checks for errors
  // ACCESS | counting down wait states, access happens when count reaches 0
  // DONE   | one-cycle ready_o (and err_o) pulse
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0]        ROM_W      = 4'(ROM_WAIT);
  localparam logic [3:0]        RAM_W      = 4'(RAM_WAIT);
  localparam logic [MEM_AW-1:0] RAM_BASE_W = RAM_BASE[MEM_AW+1:2];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MEM_AW-1:0]     waddr_q, waddr_d;
  logic                  we_q, we_d;
  logic                  sel_q, sel_d;
  logic                  err_q, err_d;
  logic                  mism_q, mism_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sel_mis;
  logic                  req_bad;
  logic                  unused_addr_hi;

  // Only the word address is kept; upper address bits matter only to the select check.
  assign unused_addr_hi = ^{addr_i[ADDR_WIDTH-1:MEM_AW+2], mism_q};

  always_comb begin
    sel_mis = 1'b0;
`ifdef SEL_CHECK_EN
    sel_mis = (addr_i >= RAM_BASE) != sel_i;
`endif
    req_bad = (addr_i[1:0] != 2'b00) || (we_i && !sel_i) || sel_mis;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    err_d   = err_q;
    mism_d  = mism_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d  = sel_i ? RAM_W : ROM_W;
          err_d  = req_bad;
          mism_d = sel_mis;
          if (req_bad) begin
            state_d = DONE;
          end else begin
            // Latches only move on a valid request so errors leave memory addresses untouched.
            waddr_d = addr_i[MEM_AW+1:2];
            we_d    = we_i;
            sel_d   = sel_i;
            wdata_d = wdata_i;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = sel_q ? ram_rdata_i : rom_rdata_i;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      mism_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      mism_q  <= mism_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready_o     = (state_q == DONE);
  assign err_o       = (state_q == DONE) && err_q;
  assign rdata_o     = rdata_q;
  assign rom_addr_o  = waddr_q;
  assign ram_addr_o  = waddr_q - RAM_BASE_W;
  assign ram_wdata_o = wdata_q;
  assign ram_we_o    = (state_q == ACCESS) && (cnt_q == 4'd0) && we_q && sel_q;
`ifdef SEL_CHECK_EN
  assign sel_mismatch_o = (state_q == DONE) && mism_q;
`endif

endmodule
